// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//
// Purpose:
//   Derives NUM_CH divided clock-enable strobes and matching near-50% square
//   waves from a single fast PLL clock, replacing dedicated PLL output taps.
//   Each channel has a programmable divide ratio and an initial counter value
//   (phase), so several enables can be generated at the same rate but with a
//   fixed offset between them.
//
//   PLL lock is supervised: the asynchronous lock signal is synchronised, and
//   the enables are only released once lock has been stable for LOCK_HOLD
//   cycles. A lock drop while running stops all enables immediately and sets
//   a sticky lock_lost flag that only reset clears.
//
// Ports:
//   clk         fast PLL output, the only clock of this block
//   rst_n       asynchronous active-low reset
//   pll_locked  PLL lock indication, asynchronous to clk
//   sync_req    one-cycle pulse; while running, reloads every channel with
//               its phase so that all channels realign
//   div_ratio   per-channel divide ratio, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//               (a ratio of 0 is treated as 1)
//   phase       per-channel initial counter value, same packing
//               (clamped to ratio-1)
//   ce_o        one-cycle clock-enable strobes, one per channel
//   sq_o        square-wave version of each divided clock (data, not a clock)
//   ready       high while the enables are running
//   lock_lost   sticky; lock dropped at some point after ready was high
// -----------------------------------------------------------------------------
module clk_enable_gen #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int LOCK_HOLD  = 1024,
    parameter int HOLD_WIDTH = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pll_locked,
    input  logic                          sync_req,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   div_ratio,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   phase,
    output logic [NUM_CH-1:0]             ce_o,
    output logic [NUM_CH-1:0]             sq_o,
    output logic                          ready,
    output logic                          lock_lost
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Last hold count before entering RUN: HOLD lasts exactly LOCK_HOLD cycles.
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(LOCK_HOLD - 1);

    // Lock synchroniser
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   lk_s;

    // Supervisor FSM
    state_t                 state_q, state_d;
    logic [HOLD_WIDTH-1:0]  hold_q, hold_d;

    // Per-channel counters and the divide ratio latched for the current period
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_CH];
    logic [CNT_WIDTH-1:0]   dq_q  [NUM_CH];
    logic [CNT_WIDTH-1:0]   dq_d  [NUM_CH];

    // Sanitised per-channel settings
    logic [CNT_WIDTH-1:0]   div_eff   [NUM_CH];
    logic [CNT_WIDTH-1:0]   phase_eff [NUM_CH];

    // Registered outputs
    logic [NUM_CH-1:0]      ce_q, ce_d;
    logic [NUM_CH-1:0]      sq_q, sq_d;
    logic                   ready_q, ready_d;
    logic                   lost_q, lost_d;

    // Control decoded from the FSM transition
    logic                   run_stay;
    logic                   load;

    // -------------------------------------------------------------------------
    // Two-flop lock synchroniser; everything downstream looks at lk_s only.
    // -------------------------------------------------------------------------
    always_comb begin
        sync1_d = pll_locked;
        sync2_d = sync1_q;
    end

    assign lk_s = sync2_q;

    // -------------------------------------------------------------------------
    // Lock supervisor next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;

        case (state_q)
            WAIT_LOCK: begin
                hold_d = '0;
                if (lk_s) begin
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            RUN: begin
                hold_d = '0;
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                hold_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs are only produced on cycles where RUN continues, so that a lock
    // drop removes ready, ce_o and sq_o on the same edge as the state change.
    // Channels load on RUN entry or on a sync request while already in RUN;
    // a lock drop takes priority over a coincident sync request.
    // -------------------------------------------------------------------------
    always_comb begin
        run_stay = (state_q == RUN) && (state_d == RUN);
        load     = (state_d == RUN) && ((state_q != RUN) || sync_req);
        ready_d  = (state_d == RUN);
        lost_d   = lost_q | ((state_q == RUN) && (state_d != RUN));
    end

    // -------------------------------------------------------------------------
    // Sanitise channel settings: ratio 0 acts as 1, phase clamps to ratio-1.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_eff[i]   = div_ratio[i*CNT_WIDTH +: CNT_WIDTH];
            phase_eff[i] = phase[i*CNT_WIDTH +: CNT_WIDTH];
            if (div_eff[i] == '0) begin
                div_eff[i] = CNT_WIDTH'(1);
            end
            if (phase_eff[i] > (div_eff[i] - 1'b1)) begin
                phase_eff[i] = div_eff[i] - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Channel counters and output decode. A new ratio is only picked up at the
    // wrap so the running period is never cut short. The square-wave threshold
    // is computed one bit wider so ceil(dq/2) cannot overflow.
    // -------------------------------------------------------------------------
    always_comb begin
        logic             last;
        logic [CNT_WIDTH:0] sq_thr;

        ce_d   = '0;
        sq_d   = '0;
        last   = 1'b0;
        sq_thr = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            dq_d[i]  = dq_q[i];

            last   = (cnt_q[i] == (dq_q[i] - 1'b1));
            sq_thr = ({1'b0, dq_q[i]} + 1'b1) >> 1;

            ce_d[i] = run_stay && last;
            sq_d[i] = run_stay && ({1'b0, cnt_q[i]} < sq_thr);

            if (state_d != RUN) begin
                cnt_d[i] = '0;
                dq_d[i]  = '0;
            end else if (load) begin
                cnt_d[i] = phase_eff[i];
                dq_d[i]  = div_eff[i];
            end else if (last) begin
                cnt_d[i] = '0;
                dq_d[i]  = div_eff[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            ce_q    <= '0;
            sq_q    <= '0;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                dq_q[i]  <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            ce_q    <= ce_d;
            sq_q    <= sq_d;
            ready_q <= ready_d;
            lost_q  <= lost_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                dq_q[i]  <= dq_d[i];
            end
        end
    end

    assign ce_o      = ce_q;
    assign sq_o      = sq_q;
    assign ready     = ready_q;
    assign lock_lost = lost_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_enable_gen
//
// Testbench for clk_enable_gen with NUM_CH=4, CNT_WIDTH=8, LOCK_HOLD=16.
// A behavioural reference model tracks lock streaks and each channel's
// position within its period; a compare process checks every output on every
// falling edge. Directed sections pin the model with hand-derived timings,
// then a long randomized section exercises ratios, phases, sync and lock loss.
// -----------------------------------------------------------------------------
module tb_clk_enable_gen;

    localparam int NUM_CH     = 4;
    localparam int CNT_WIDTH  = 8;
    localparam int LOCK_HOLD  = 16;
    localparam int HOLD_WIDTH = 5;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        pll_locked;
    logic                        sync_req;
    logic [NUM_CH*CNT_WIDTH-1:0] div_ratio;
    logic [NUM_CH*CNT_WIDTH-1:0] phase;
    logic [NUM_CH-1:0]           ce_o;
    logic [NUM_CH-1:0]           sq_o;
    logic                        ready;
    logic                        lock_lost;

    int errors = 0;
    int checks = 0;

    clk_enable_gen #(
        .NUM_CH     (NUM_CH),
        .CNT_WIDTH  (CNT_WIDTH),
        .LOCK_HOLD  (LOCK_HOLD),
        .HOLD_WIDTH (HOLD_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .sync_req   (sync_req),
        .div_ratio  (div_ratio),
        .phase      (phase),
        .ce_o       (ce_o),
        .sq_o       (sq_o),
        .ready      (ready),
        .lock_lost  (lock_lost)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive all functional inputs in one go.
    task automatic applyStimulus(input logic [31:0] div, input logic [31:0] ph,
                                 input logic lk, input logic sr);
        div_ratio  = div;
        phase      = ph;
        pll_locked = lk;
        sync_req   = sr;
    endtask

    // -------------------------------------------------------------------------
    // Reference model. Lock is seen two edges late; the block runs once lock
    // has been seen on more than LOCK_HOLD consecutive edges. Each channel is
    // described by the edge at which its current period segment started, the
    // position it started from and the period length in force.
    // -------------------------------------------------------------------------
    int        h1 = 0, h2 = 0, streak = 0, cyc = 0;
    bit        m_run = 0, m_ready = 0, m_lost = 0;
    bit [3:0]  m_ce = '0, m_sq = '0;
    int        anchor [NUM_CH];
    int        off    [NUM_CH];
    int        per    [NUM_CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 = 0; h2 = 0; streak = 0; cyc = 0;
            m_run = 0; m_ready = 0; m_lost = 0;
            m_ce = '0; m_sq = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                anchor[i] = 0; off[i] = 0; per[i] = 0;
            end
        end else begin
            int  lk, pos, d, p;
            bit  run_cur, run_next, stay;
            lk = h2;
            h2 = h1;
            h1 = int'(pll_locked);
            run_cur = m_run;
            if (lk != 0) begin
                if (streak < 1000000) streak++;
            end else begin
                streak = 0;
            end
            run_next = (streak >= LOCK_HOLD + 1);
            stay     = run_cur && run_next;
            for (int i = 0; i < NUM_CH; i++) begin
                pos = off[i] + (cyc - anchor[i]);
                d   = int'(div_ratio[i*CNT_WIDTH +: CNT_WIDTH]);
                if (d == 0) d = 1;
                p   = int'(phase[i*CNT_WIDTH +: CNT_WIDTH]);
                if (p > d - 1) p = d - 1;
                m_ce[i] = stay && (pos == per[i] - 1);
                m_sq[i] = stay && (pos < (per[i] + 1) / 2);
                if (!run_next) begin
                    per[i] = 0; off[i] = 0; anchor[i] = cyc + 1;
                end else if (!run_cur || sync_req) begin
                    per[i] = d; off[i] = p; anchor[i] = cyc + 1;
                end else if (pos == per[i] - 1) begin
                    per[i] = d; off[i] = 0; anchor[i] = cyc + 1;
                end
            end
            if (run_cur && !run_next) m_lost = 1;
            m_ready = run_next;
            m_run   = run_next;
            cyc++;
        end
    end

    // -------------------------------------------------------------------------
    // Continuous comparison of all outputs against the model.
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("ready", 32'(ready), 32'(m_ready));
            checkOutput("lock_lost", 32'(lock_lost), 32'(m_lost));
            checkOutput("ce_o", 32'(ce_o), 32'(m_ce));
            checkOutput("sq_o", 32'(sq_o), 32'(m_sq));
        end
    end

    // Logs of outputs for the hand-derived timing checks.
    logic [3:0] ce_log [0:63];
    logic [3:0] sq_log [0:63];

    // First log index at or after 'from' where channel ch strobed, or -1.
    function automatic int firstCe(input int ch, input int from, input int upto);
        for (int j = from; j <= upto; j++) begin
            if (ce_log[j][ch] === 1'b1) return j;
        end
        return -1;
    endfunction

    function automatic int countCe(input int ch, input int from, input int upto);
        int n = 0;
        for (int j = from; j <= upto; j++) begin
            if (ce_log[j][ch] === 1'b1) n++;
        end
        return n;
    endfunction

    function automatic int countSq(input int ch, input int from, input int upto);
        int n = 0;
        for (int j = from; j <= upto; j++) begin
            if (sq_log[j][ch] === 1'b1) n++;
        end
        return n;
    endfunction

    // Fill log entries 1..n from consecutive falling edges.
    task automatic recordLog(input int n);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            ce_log[j] = ce_o;
            sq_log[j] = sq_o;
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence followed by randomized traffic.
    // -------------------------------------------------------------------------
    initial begin
        int k;
        bit ce_early;
        int drop_left;

        for (int j = 0; j < 64; j++) begin
            ce_log[j] = '0;
            sq_log[j] = '0;
        end

        // Reset held with lock already asserted: everything stays quiet.
        rst_n = 1'b0;
        applyStimulus(32'h01031212, 32'h00000E00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_ce", 32'(ce_o), 32'd0);
        checkOutput("rst_sq", 32'(sq_o), 32'd0);
        checkOutput("rst_lock_lost", 32'(lock_lost), 32'd0);

        // Release: 2 sync edges + 1 to HOLD + 16 hold cycles = 19 edges.
        rst_n    = 1'b1;
        k        = -1;
        ce_early = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                k = n;
                break;
            end
            if (ce_o !== 4'b0) ce_early = 1'b1;
        end
        checkOutput("ready_latency", 32'(k), 32'd19);
        checkOutput("ce_before_ready", 32'(ce_early), 32'd0);

        // Ratios {ch3=1, ch2=3, ch1=18 phase 14, ch0=18}, log 40 edges after ready.
        recordLog(40);
        checkOutput("ch3_first_ce", 32'(firstCe(3, 1, 40)), 32'd1);
        checkOutput("ch3_ce_count", 32'(countCe(3, 1, 40)), 32'd40);
        checkOutput("ch2_first_ce", 32'(firstCe(2, 1, 40)), 32'd3);
        checkOutput("ch2_ce_count", 32'(countCe(2, 1, 40)), 32'd13);
        checkOutput("ch1_first_ce", 32'(firstCe(1, 1, 40)), 32'd4);
        checkOutput("ch1_second_ce", 32'(firstCe(1, 5, 40)), 32'd22);
        checkOutput("ch0_first_ce", 32'(firstCe(0, 1, 40)), 32'd18);
        checkOutput("ch0_second_ce", 32'(firstCe(0, 19, 40)), 32'd36);
        checkOutput("ch0_sq_high", 32'(countSq(0, 1, 18)), 32'd9);

        // Change ch2 from 3 to 5 mid-period: current period ends at 3, next is 5.
        applyStimulus(32'h01051212, 32'h00000E00, 1'b1, 1'b0);
        recordLog(12);
        checkOutput("ratio_chg_first", 32'(firstCe(2, 1, 12)), 32'd2);
        checkOutput("ratio_chg_second", 32'(firstCe(2, 3, 12)), 32'd7);
        checkOutput("ratio_chg_count", 32'(countCe(2, 1, 11)), 32'd2);

        // Sync with ch1 phase 40 (clamps to 17): ch1 strobes right after load.
        applyStimulus(32'h01051212, 32'h00002800, 1'b1, 1'b1);
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            ce_log[j] = ce_o;
            sq_log[j] = sq_o;
            if (j == 1) sync_req = 1'b0;
        end
        checkOutput("sync_ch1_clamped", 32'(ce_log[2][1]), 32'd1);
        checkOutput("sync_ch1_next", 32'(firstCe(1, 3, 24)), 32'd20);
        checkOutput("sync_ch2_first", 32'(firstCe(2, 2, 24)), 32'd6);
        checkOutput("sync_ch0_first", 32'(firstCe(0, 2, 24)), 32'd19);

        // One-cycle lock drop in RUN: outputs stop on the third edge, relock
        // brings ready back 20 edges after the drop, lock_lost stays set.
        pll_locked = 1'b0;
        k = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) pll_locked = 1'b1;
            if (n == 2) checkOutput("drop_ready_n2", 32'(ready), 32'd1);
            if (n == 3) begin
                checkOutput("drop_ready_n3", 32'(ready), 32'd0);
                checkOutput("drop_ce_n3", 32'(ce_o), 32'd0);
                checkOutput("drop_lost_n3", 32'(lock_lost), 32'd1);
            end
            if (n > 3 && ready === 1'b1) begin
                k = n;
                break;
            end
        end
        checkOutput("relock_latency", 32'(k), 32'd20);
        checkOutput("relock_lost_sticky", 32'(lock_lost), 32'd1);

        // Asynchronous reset between edges clears outputs without a clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ready", 32'(ready), 32'd0);
        checkOutput("async_rst_ce", 32'(ce_o), 32'd0);
        checkOutput("async_rst_sq", 32'(sq_o), 32'd0);
        checkOutput("async_rst_lost", 32'(lock_lost), 32'd0);
        repeat (2) @(negedge clk);

        // Lock glitch during HOLD restarts the hold; ready at edge 28, no lock_lost.
        rst_n = 1'b1;
        k = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                k = n;
                break;
            end
            if (n == 8) pll_locked = 1'b0;
            if (n == 9) pll_locked = 1'b1;
        end
        checkOutput("hold_glitch_latency", 32'(k), 32'd28);
        checkOutput("hold_glitch_lost", 32'(lock_lost), 32'd0);

        // Randomized ratios, phases, sync pulses and occasional lock drops.
        for (int i = 0; i < NUM_CH; i++) begin
            div_ratio[i*CNT_WIDTH +: CNT_WIDTH] = 8'($urandom_range(0, 20));
            phase[i*CNT_WIDTH +: CNT_WIDTH]     = 8'($urandom_range(0, 40));
        end
        drop_left = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                int ch;
                ch = int'($urandom_range(0, NUM_CH - 1));
                div_ratio[ch*CNT_WIDTH +: CNT_WIDTH] = 8'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 15) == 0) begin
                int ch;
                ch = int'($urandom_range(0, NUM_CH - 1));
                phase[ch*CNT_WIDTH +: CNT_WIDTH] = 8'($urandom_range(0, 40));
            end
            sync_req = ($urandom_range(0, 15) == 0);
            if (drop_left > 0) begin
                pll_locked = 1'b0;
                drop_left--;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 399) == 0) drop_left = int'($urandom_range(1, 3));
            end
        end

        sync_req = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
Parametrised clock-enable generator that replaces fixed extra PLL output taps. It runs on one fast PLL output, e.g. 110.592 MHz, and derives NUM_CH divided enables with programmable phase, e.g. 36.864 MHz (div 3) and 6.144 MHz (div 18) plus a phase-shifted 6.144 MHz copy. It supervises PLL lock: after lock has been stable for a hold time it releases the enables and raises ready. On lock loss it stops all enables and records the event.

Parameters:
NUM_CH, 4, number of enable channels (1..16)
CNT_WIDTH, 8, width of each channel's divide/phase counter
LOCK_HOLD, 1024, clk cycles of continuous synchronised lock required before RUN (>=1)
HOLD_WIDTH, 11, width of lock-hold counter; must hold LOCK_HOLD

Ports:
clk  in  1  single core clock, fast PLL output
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock, asynchronous to clk
sync_req  in  1  one-cycle pulse; realigns all channels to their phases
div_ratio  in  NUM_CH*CNT_WIDTH  per-channel divide ratio, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
phase  in  NUM_CH*CNT_WIDTH  per-channel initial counter value, same packing
ce_o  out  NUM_CH  one-cycle clock-enable strobes
sq_o  out  NUM_CH  near-50% square-wave versions (divided clock as data, not a clock)
ready  out  1  high while in RUN
lock_lost  out  1  sticky flag; a lock drop occurred after ready first rose

Behaviour:
- Reset (rst_n low, asynchronous): state=WAIT_LOCK; both sync flops, hold counter, all channel counters, ce_o, sq_o, ready and lock_lost are 0.
- Lock sync: 2-flop synchroniser gives lk_s. All decisions use lk_s only.
- FSM:
  - WAIT_LOCK: hold counter 0. When lk_s=1, go to HOLD.
  - HOLD: hold counter increments each cycle with lk_s=1. If lk_s=0, go to WAIT_LOCK. When count reaches LOCK_HOLD-1, go to RUN and load channels.
  - RUN: ready=1 (registered; same cycle as state). If lk_s=0, go to WAIT_LOCK: ready, ce_o, sq_o drop the next cycle, and lock_lost is set.
- lock_lost stays high until rst_n; the FSM still re-locks normally.
- Channel i effective divide d_i = max(div_ratio_i, 1); divide 0 is treated as 1.
- Phase p_i = phase_i clamped to d_i-1.
- Load (RUN entry, or sync_req=1 while in RUN): cnt_i <= p_i, dq_i <= d_i.
- sync_req outside RUN is ignored.
- Count in RUN: if cnt_i==dq_i-1 then cnt_i<=0 and dq_i<=d_i (new ratio takes effect only at wrap), else cnt_i<=cnt_i+1. Load has priority over count.
- Outputs are registered from the current cnt_i, one cycle of latency:
  - ce_o[i] <= run && (cnt_i==dq_i-1)
  - sq_o[i] <= run && (cnt_i < ceil(dq_i/2))
  - Odd divide: high phase is one cycle longer.
- Divide 1: cnt stays 0, ce_o continuously high, sq_o high.
- Simultaneous lock drop and sync_req: lock drop wins; counters are cleared in WAIT_LOCK.
- Outside RUN: ce_o=0, sq_o=0, counters held at 0.
- All arithmetic is unsigned CNT_WIDTH. There is no overflow because cnt < dq <= 2^CNT_WIDTH-1.

Test Plan:
- Reset/lock: rst_n low with pll_locked=1 -> all outputs 0. Release rst_n, LOCK_HOLD=16 -> ready rises exactly 2+1+16 cycles after release (2 sync flops, WAIT_LOCK to HOLD, hold count). ce_o stays 0 before that.
- Ratios: div={18,18,3,1}, phase=0 -> ch2 ce every 3rd cycle, first in RUN cycle 3. ch0 ce period 18; sq_o[0] is 9 high / 9 low. ch3 ce constantly 1 from RUN cycle 1.
- Phase: ch1 phase=14, ch0 phase=0, div 18 -> ch1 ce leads ch0 by 14 cycles, i.e. lags by 4, every period. Phase=40 with div 18 -> behaves as phase 17.
- Ratio change mid-run: ch2 div 3->5 applied mid-period -> the current period completes at 3, the next period is 5. Then sync_req -> all counters reload on the following cycle and ce spacing restarts from phase.
- Lock glitch: drop pll_locked for 1 cycle in HOLD -> FSM returns to WAIT_LOCK and the hold restarts, lock_lost stays 0. Drop in RUN -> ready and ce_o go to 0 within 3 cycles and lock_lost=1; re-lock -> ready returns after the hold time, lock_lost remains 1.
- Async reset mid-RUN: rst_n low between clk edges -> outputs are 0 immediately with no clock edge required.
